counter_cmd_sequencer: RTL and testbench



---
 rtl/counter_cmd_sequencer.sv | 136 +++++++++++++
 tb/tb_counter_cmd_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_cmd_sequencer.sv
// Command front-end for the loadable up-counter: debounces two push-buttons and
// sequences count runs or a two-nibble load of the switch byte.

module counter_cmd_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_btn_n,
  output logic o_press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          stable_q;
  logic [CW-1:0] cnt_q;
  logic          flip;

  // This edge is the DEBOUNCE_CYCLES-th consecutive disagreement.
  assign flip = (sync_q[1] != stable_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      o_press  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], i_btn_n};
      o_press <= flip && stable_q;
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (flip) begin
        cnt_q    <= '0;
        stable_q <= ~stable_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end
endmodule

module counter_cmd_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RUN_LENGTH      = 15
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_btn_count_n,
  input  logic       i_btn_load_n,
  input  logic [7:0] i_switches,
  output logic       o_cnt_enable_n,
  output logic       o_ld_enable_n,
  output logic [3:0] o_load,
  output logic       o_busy
);
  localparam int NUM_BTN = 2;
  localparam int RW      = (RUN_LENGTH > 1) ? $clog2(RUN_LENGTH) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, LOAD_LO, LOAD_HI} state_t;

  logic [NUM_BTN-1:0] btn_n, press;   // [0] count, [1] load
  assign btn_n = {i_btn_load_n, i_btn_count_n};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    counter_cmd_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_btn_n   (btn_n[g]),
      .o_press   (press[g])
    );
  end

  state_t        state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic [7:0]    ld_byte_q, ld_byte_d;
  logic          cnt_en_n_d, ld_en_n_d, busy_d;
  logic [3:0]    load_d;

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    ld_byte_d = ld_byte_q;
    case (state_q)
      IDLE: begin
        // Load has priority; a coincident count press is simply lost.
        if (press[1]) begin
          state_d   = LOAD_LO;
          ld_byte_d = i_switches;
        end else if (press[0]) begin
          state_d = COUNT;
          run_d   = RW'(RUN_LENGTH - 1);
        end
      end
      COUNT: begin
        if (run_q == '0) state_d = IDLE;
        else             run_d   = run_q - RW'(1);
      end
      LOAD_LO: state_d = LOAD_HI;
      LOAD_HI: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs decoded from the next state so they can be registered.
    cnt_en_n_d = 1'b1;
    ld_en_n_d  = 1'b1;
    load_d     = 4'h0;
    busy_d     = 1'b0;
    case (state_d)
      COUNT:   begin cnt_en_n_d = 1'b0; busy_d = 1'b1; end
      LOAD_LO: begin ld_en_n_d = 1'b0; load_d = ld_byte_d[3:0]; busy_d = 1'b1; end
      LOAD_HI: begin ld_en_n_d = 1'b0; load_d = ld_byte_d[7:4]; busy_d = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q        <= IDLE;
      run_q          <= '0;
      ld_byte_q      <= '0;
      o_cnt_enable_n <= 1'b1;
      o_ld_enable_n  <= 1'b1;
      o_load         <= 4'h0;
      o_busy         <= 1'b0;
    end else begin
      state_q        <= state_d;
      run_q          <= run_d;
      ld_byte_q      <= ld_byte_d;
      o_cnt_enable_n <= cnt_en_n_d;
      o_ld_enable_n  <= ld_en_n_d;
      o_load         <= load_d;
      o_busy         <= busy_d;
    end
  end
endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Bench for counter_cmd_sequencer: directed plan steps plus random presses, every
// cycle compared against a timeline-based reference model.

module tb_counter_cmd_sequencer;
  localparam int DEB = 4;
  localparam int RUN = 15;

  logic       clk, rst_n, btn_c, btn_l;
  logic [7:0] sw;
  logic       cnt_n, ld_n, busy;
  logic [3:0] load;

  counter_cmd_sequencer #(.DEBOUNCE_CYCLES(DEB), .RUN_LENGTH(RUN)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_btn_count_n  (btn_c),
    .i_btn_load_n   (btn_l),
    .i_switches     (sw),
    .o_cnt_enable_n (cnt_n),
    .o_ld_enable_n  (ld_n),
    .o_load         (load),
    .o_busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model: raw-sample history, per-button disagreement run length,
  // and the active operation as a window of edge numbers.
  int         cyc = 0;
  logic [1:0] hist[$];
  logic [1:0] m_stable, m_ev;
  int         m_mis[2];
  int         m_kind;          // 0 none, 1 count, 2 load
  int         m_start, m_end;
  logic [7:0] m_byte;

  task automatic model_reset();
    hist.delete();
    hist.push_back(2'b11);
    hist.push_back(2'b11);
    m_stable = 2'b11;
    m_ev     = 2'b00;
    m_mis[0] = 0;
    m_mis[1] = 0;
    m_kind   = 0;
  endtask

  task automatic model_edge();
    logic [1:0] syn;
    cyc++;
    if (!rst_n) begin model_reset(); return; end
    syn = hist[hist.size()-2];
    if (m_kind == 0 || cyc - 1 > m_end) begin
      if (m_ev[1]) begin
        m_kind = 2; m_start = cyc; m_end = cyc + 1; m_byte = sw;
      end else if (m_ev[0]) begin
        m_kind = 1; m_start = cyc; m_end = cyc + RUN - 1;
      end
    end
    m_ev = 2'b00;
    for (int b = 0; b < 2; b++) begin
      if (syn[b] != m_stable[b]) begin
        m_mis[b]++;
        if (m_mis[b] == DEB) begin
          m_stable[b] = ~m_stable[b];
          m_mis[b]    = 0;
          m_ev[b]     = !m_stable[b];
        end
      end else m_mis[b] = 0;
    end
    hist.push_back({btn_l, btn_c});
    if (hist.size() > 4) void'(hist.pop_front());
  endtask

  int mon_cnt_low, mon_ld_low, mon_first;

  task automatic mon_clear();
    mon_cnt_low = 0; mon_ld_low = 0; mon_first = -1;
  endtask

  task automatic check_outputs();
    logic       act;
    logic [3:0] exp_load;
    act      = (m_kind != 0) && (cyc >= m_start) && (cyc <= m_end);
    exp_load = 4'h0;
    if (act && m_kind == 2) exp_load = (cyc == m_start) ? m_byte[3:0] : m_byte[7:4];
    chk("cnt_enable_n", cnt_n, !(act && m_kind == 1));
    chk("ld_enable_n",  ld_n,  !(act && m_kind == 2));
    chk("load",         load,  exp_load);
    chk("busy",         busy,  act);
    chk("enables_exclusive", !(cnt_n === 1'b0 && ld_n === 1'b0), 1'b1);
    if (cnt_n === 1'b0) begin
      if (mon_first < 0) mon_first = cyc;
      mon_cnt_low++;
    end
    if (ld_n === 1'b0) mon_ld_low++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  int t0;
  logic [1:0] sel;

  initial begin
    btn_c = 1'b1; btn_l = 1'b1; sw = 8'h00; rst_n = 1'b1;
    model_reset();
    mon_clear();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cnt_enable_n", cnt_n, 1'b1);
    chk("rst_ld_enable_n",  ld_n,  1'b1);
    chk("rst_load",         load,  4'h0);
    chk("rst_busy",         busy,  1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Count press: 10 cycles low, run starts at edge DEB+3 and lasts RUN.
    mon_clear(); t0 = cyc; btn_c = 1'b0;
    repeat (10) tick();
    btn_c = 1'b1;
    repeat (25) tick();
    chk("count_first_edge", mon_first, t0 + DEB + 3);
    chk("count_run_len",    mon_cnt_low, RUN);
    chk("count_no_load",    mon_ld_low, 0);

    // Load 0xC3; switches cleared during LOAD_LO.
    mon_clear(); sw = 8'hC3; btn_l = 1'b0;
    repeat (DEB + 3) tick();
    chk("load_lo_nibble", load, 4'h3);
    sw = 8'h00;
    tick();
    chk("load_hi_nibble", load, 4'hC);
    btn_l = 1'b1;
    repeat (15) tick();
    chk("load_len", mon_ld_low, 2);

    // Glitch of 3 cycles rejected; 4-cycle pulse gives one run.
    mon_clear(); btn_c = 1'b0;
    repeat (3) tick();
    btn_c = 1'b1;
    repeat (15) tick();
    chk("glitch_rejected", mon_cnt_low, 0);
    btn_c = 1'b0;
    repeat (4) tick();
    btn_c = 1'b1;
    repeat (25) tick();
    chk("pulse4_run_len", mon_cnt_low, RUN);

    // Simultaneous press: load only.
    mon_clear(); sw = 8'h5A; btn_c = 1'b0; btn_l = 1'b0;
    repeat (8) tick();
    btn_c = 1'b1; btn_l = 1'b1;
    repeat (15) tick();
    chk("both_no_count", mon_cnt_low, 0);
    chk("both_load_len", mon_ld_low, 2);

    // Load during COUNT dropped; a later load works.
    mon_clear(); btn_c = 1'b0;
    repeat (8) tick();
    btn_l = 1'b0;
    repeat (2) tick();
    btn_c = 1'b1;
    repeat (6) tick();
    btn_l = 1'b1;
    repeat (20) tick();
    chk("conflict_run_len", mon_cnt_low, RUN);
    chk("conflict_no_load", mon_ld_low, 0);
    mon_clear(); sw = 8'h96; btn_l = 1'b0;
    repeat (8) tick();
    btn_l = 1'b1;
    repeat (12) tick();
    chk("later_load_len", mon_ld_low, 2);

    // Reset mid-COUNT with the button held.
    mon_clear(); btn_c = 1'b0;
    repeat (DEB + 7) tick();
    chk("pre_reset_run", mon_cnt_low, 5);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_cnt_enable_n", cnt_n, 1'b1);
    chk("midrst_ld_enable_n",  ld_n,  1'b1);
    chk("midrst_load",         load,  4'h0);
    chk("midrst_busy",         busy,  1'b0);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    mon_clear(); t0 = cyc;
    repeat (30) tick();
    chk("post_reset_first_edge", mon_first, t0 + DEB + 3);
    chk("post_reset_run_len",    mon_cnt_low, RUN);
    btn_c = 1'b1;
    repeat (10) tick();

    // Random presses, durations, gaps and switch changes.
    for (int i = 0; i < 60; i++) begin
      sw    = 8'($urandom);
      sel   = 2'($urandom_range(1, 3));
      btn_c = !sel[0];
      btn_l = !sel[1];
      repeat ($urandom_range(1, 9)) begin
        tick();
        if ($urandom_range(0, 3) == 0) sw = 8'($urandom);
      end
      btn_c = 1'b1; btn_l = 1'b1;
      repeat ($urandom_range(0, 22)) tick();
    end
    repeat (25) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
